sos_pin_tx_module: RTL and testbench

- Transmit-side counterpart of the key debounce path: converts a one-clock command pulse into a timed Morse "SOS" waveform on an output pin (LED/buzzer).
- The debounced key pulse drives Start_Sig.
- Sits between the key/control logic and the board pin.
- All timing is derived from a single unit-length counter.

---
 rtl/sos_pin_tx_module.sv | 79 +++++++
 tb/tb_sos_pin_tx_module.sv | 117 +++++++++++
 2 files changed

// File: rtl/sos_pin_tx_module.sv
// sos_pin_tx_module: one-pulse command to timed Morse "SOS" waveform on a pin; define SOS_REPEAT_EN for auto-repeat with stop request
module sos_pin_tx_module #(
    parameter int UNIT_CYCLES = 5000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic Start_Sig,
    output logic Pin_Out,
    output logic Busy_Sig,
    output logic Done_Sig
);
    localparam int UW = $clog2(UNIT_CYCLES);
    localparam logic [UW-1:0] U_LAST = UW'(UNIT_CYCLES - 1);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MARK = 3'd1;
    localparam logic [2:0] GAP  = 3'd2;
    localparam logic [2:0] DONE = 3'd3;
`ifdef SOS_REPEAT_EN
    localparam logic [2:0] WGAP = 3'd4;
    logic stop;
`endif
    logic [2:0] state, nxt;
    logic [UW-1:0] ucnt;
    logic [1:0] ecnt, mark_last, gap_last;
    logic [3:0] elem;
    logic tick, run_end;
    assign tick = ucnt == U_LAST;
    assign mark_last = (elem >= 4'd3 && elem <= 4'd5) ? 2'd2 : 2'd0;
    assign gap_last = (elem == 4'd2 || elem == 4'd5) ? 2'd2 : 2'd0;
    assign run_end = tick && ecnt == (state == MARK ? mark_last : gap_last);
    // next-state selection; outputs are registered from it so the pin never glitches
    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = Start_Sig ? MARK : IDLE;
            MARK: nxt = run_end ? (elem == 4'd8 ? DONE : GAP) : MARK;
            GAP:  nxt = run_end ? MARK : GAP;
`ifdef SOS_REPEAT_EN
            DONE: nxt = stop ? IDLE : WGAP;
            WGAP: nxt = Start_Sig ? IDLE : (tick && elem == 4'd6) ? MARK : WGAP;
`else
            DONE: nxt = IDLE;
`endif
            default: nxt = IDLE;
        endcase
    end
    // state, unit/element counters and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            ucnt <= '0;
            ecnt <= '0;
            elem <= '0;
            Pin_Out <= 1'b0;
            Busy_Sig <= 1'b0;
            Done_Sig <= 1'b0;
`ifdef SOS_REPEAT_EN
            stop <= 1'b0;
`endif
        end else begin
            state <= nxt;
            Pin_Out <= nxt == MARK;
            Done_Sig <= nxt == DONE;
            ucnt <= (state == IDLE || tick) ? '0 : ucnt + 1'b1;
            ecnt <= state == IDLE ? 2'd0 :
                    ((state == MARK || state == GAP) && tick) ? (run_end ? 2'd0 : ecnt + 2'd1) : ecnt;
            elem <= (state == IDLE || state == DONE) ? 4'd0 :
                    (state == GAP && run_end) ? elem + 4'd1 : elem;
`ifdef SOS_REPEAT_EN
            Busy_Sig <= nxt == MARK || nxt == GAP || nxt == WGAP;
            stop <= (state == MARK || state == GAP) ? (stop | Start_Sig) : 1'b0;
            if (state == WGAP && tick)
                elem <= elem == 4'd6 ? 4'd0 : elem + 4'd1;
`else
            Busy_Sig <= nxt == MARK || nxt == GAP;
`endif
        end
    end
endmodule

// File: tb/tb_sos_pin_tx_module.sv
// tb_sos_pin_tx_module: random start/reset stimulus checked against a word-timeline model
module tb_sos_pin_tx_module;
    localparam int U = 4;
    localparam int WORD = 27 * U;
    localparam int GAP_LAST = WORD + 7 * U - 1;
    logic CLK, RST, Start_Sig;
    logic Pin_Out, Busy_Sig, Done_Sig;
    int n_checks = 0;
    int n_fail = 0;
    int p = -1;
    bit stop = 0;
    bit word[WORD];
    int marks[9] = '{1, 1, 1, 3, 3, 3, 1, 1, 1};
    int gaps[8] = '{1, 1, 3, 1, 1, 3, 1, 1};
    int mark_cnt, done_cnt;

    sos_pin_tx_module #(.UNIT_CYCLES(U)) dut (
        .CLK(CLK), .RST(RST), .Start_Sig(Start_Sig),
        .Pin_Out(Pin_Out), .Busy_Sig(Busy_Sig), .Done_Sig(Done_Sig)
    );

    initial CLK = 0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d (pos %0d)", tag, $time, got, exp, p);
        end
    endtask

    task automatic compare_all();
        check("pin", 32'(Pin_Out), 32'(p >= 0 && p < WORD && word[p]));
        check("busy", 32'(Busy_Sig), 32'((p >= 0 && p < WORD) || p > WORD));
        check("done", 32'(Done_Sig), 32'(p == WORD));
    endtask

    task automatic model_update(input bit s);
        if (p < 0) begin
            if (s) p = 0;
        end else if (p < WORD) begin
            if (s) stop = 1;
            p++;
        end else if (p == WORD) begin
`ifdef SOS_REPEAT_EN
            if (stop) begin p = -1; stop = 0; end
            else p++;
`else
            p = -1;
            stop = 0;
`endif
        end else begin
            if (s) p = -1;
            else p = (p == GAP_LAST) ? 0 : p + 1;
        end
    endtask

    task automatic step(input bit s);
        @(negedge CLK);
        Start_Sig = s;
        @(posedge CLK);
        model_update(s);
        #1 compare_all();
        if (Pin_Out) mark_cnt++;
        if (Done_Sig) done_cnt++;
    endtask

    task automatic rst_mid();
        #2 RST = 1;
        Start_Sig = 0;
        #1;
        check("rst_pin", 32'(Pin_Out), 0);
        check("rst_busy", 32'(Busy_Sig), 0);
        check("rst_done", 32'(Done_Sig), 0);
        p = -1;
        stop = 0;
        @(negedge CLK);
        RST = 0;
    endtask

    initial begin
        int idx = 0;
        for (int e = 0; e < 9; e++) begin
            for (int c = 0; c < marks[e] * U; c++) word[idx++] = 1;
            if (e < 8) for (int c = 0; c < gaps[e] * U; c++) word[idx++] = 0;
        end
        RST = 1;
        Start_Sig = 0;
        #1 compare_all();
        repeat (3) @(negedge CLK);
        RST = 0;
        step(0);
        mark_cnt = 0;
        done_cnt = 0;
        step(1);
        for (int i = 0; i < WORD - 1; i++) step(i == 9);
        check("mark_cycles", 32'(mark_cnt), 60);
        check("done_early", 32'(done_cnt), 0);
        step(1);
        check("done_once", 32'(done_cnt), 1);
        step(1);
        step(1);
        if (p < 0) step(1);
        for (int i = 0; i < 300 && p != 30; i++) step(0);
        check("reach_mid", 32'(p), 30);
        rst_mid();
        step(1);
        for (int i = 0; i < WORD + 2; i++) step(0);
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 799) == 0) rst_mid();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
